decode_commit_wait_scheduler: RTL and testbench
===============================================

// Module: decode_commit_wait_scheduler
// PURPOSE
//  Issue scheduler between the decoder output and dispatch. Passes decoded instructions on with
//  1-cycle latency and bounds the number of issued-but-uncommitted instructions.
//  Serialises FRONT_COMMIT_WAIT instructions: drains the in-flight window, issues the instruction
//  alone, then holds further issue until it commits.
// PARAMETERS
//  DATA_W        64  width of the opaque decoded payload passed through (cmd, operands, flags)
//  MAX_INFLIGHT  16  maximum issued-but-uncommitted instructions, range 1..255
//  CNT_W         local, $clog2(MAX_INFLIGHT+1): width of the in-flight counter
// PORTS
//  iCLOCK                  in   1       clock; all state updates on the rising edge
//  iRESET                  in   1       reset, asynchronous, active-high
//  iFREE_DEFAULT           in   1       synchronous pipeline flush
//  iPREVIOUS_VALID         in   1       decoded instruction valid
//  iPREVIOUS_COMMIT_WAIT   in   1       instruction is FRONT_COMMIT_WAIT class
//  iPREVIOUS_PC            in   32      instruction PC
//  iPREVIOUS_DATA          in   DATA_W  decoded payload
//  oPREVIOUS_LOCK          out  1       upstream must hold its current instruction
//  oNEXT_VALID             out  1       registered instruction valid
//  oNEXT_COMMIT_WAIT       out  1       registered commit-wait tag
//  oNEXT_PC                out  32      registered PC
//  oNEXT_DATA              out  DATA_W  registered payload
//  iNEXT_LOCK              in   1       downstream stall
//  iCOMMIT_VALID           in   1       one instruction retired this cycle
//  oINFLIGHT               out  CNT_W   current in-flight count
//  oCOUNT_ERROR            out  1       sticky: commit received while in-flight count was 0
// BEHAVIOUR
//  Reset/flush values: all outputs 0, state RUN, in-flight count 0. Flush takes priority over all
//    other events and discards in-flight accounting. Async reset mid-operation gives the same values.
//  Output register: loads {valid&accept, cw, pc, data} whenever !iNEXT_LOCK and holds otherwise.
//    If the input is locked while !iNEXT_LOCK, the register loads a bubble (valid=0).
//  Accept = iPREVIOUS_VALID & !oPREVIOUS_LOCK.
//  Issue = oNEXT_VALID & !iNEXT_LOCK.
//  Counter: +1 on issue, -1 on iCOMMIT_VALID, unchanged when both occur in the same cycle.
//    A commit at count 0 is ignored and sets oCOUNT_ERROR.
//  full = (oINFLIGHT + oNEXT_VALID) >= MAX_INFLIGHT.
//  FSM states:
//   RUN: oPREVIOUS_LOCK = iNEXT_LOCK | full | (iPREVIOUS_VALID & iPREVIOUS_COMMIT_WAIT).
//     A valid CW input -> DRAIN (the CW is not accepted this cycle).
//   DRAIN: locked, except in the single cycle where !oNEXT_VALID & oINFLIGHT==0 & !iNEXT_LOCK.
//     In that cycle the CW is accepted and the state goes to WAIT_CW.
//   WAIT_CW: locked. When !oNEXT_VALID & oINFLIGHT==0 (the CW has issued and committed) -> RUN.
//     A commit arriving in the same cycle as the CW issue is allowed and nets to 0.
//  Latency: input to oNEXT_* is 1 cycle in RUN. A CW instruction waits for a full drain plus 1 cycle.
//  Back-to-back CW instructions: each one repeats DRAIN -> WAIT_CW -> RUN; RUN lasts at least 1 cycle.
// CONFIGURATION
//  DECODE_SCHED_STALL_CNT_EN defined:
//    - adds output oSTALL_CYCLES [31:0]
//    - increments, saturating, each cycle with iPREVIOUS_VALID & oPREVIOUS_LOCK & !iNEXT_LOCK
//      (scheduler-caused stall)
//    - cleared by reset and by flush
//  DECODE_SCHED_STALL_CNT_EN undefined: the port and the counter are absent; no other change.
// STRUCTURE
//  core.h: state encodings DECSCHED_RUN/DECSCHED_DRAIN/DECSCHED_WAIT_CW (2 bits) and the default
//    MAX_INFLIGHT constant.
//  Sub-module decode_sched_inflight_counter: up/down counter with simultaneous-event rule,
//    full compare and underflow flag.
// TESTING
//  Stream of 5 normal insts, no lock, commits lagging 3 cycles -> each appears 1 cycle later;
//    oINFLIGHT peaks at 3 and returns to 0.
//  MAX_INFLIGHT=4 with no commits -> 4 issued, then oPREVIOUS_LOCK=1 and the 5th held.
//    One commit -> the 5th issues 2 cycles later.
//  CW inst with 2 in flight -> DRAIN until 2 commits, then CW issues alone.
//    The next normal inst is held until the CW commits.
//  iNEXT_LOCK high 3 cycles with valid output -> oNEXT_* stable, no double issue, count +1 only.
//  Flush in WAIT_CW with count 2 -> next cycle: state RUN, count 0, oNEXT_VALID=0, sticky error 0.
//  Commit at count 0 -> count stays 0, oCOUNT_ERROR=1 until reset.

Source files
------------

// File: rtl/decode_commit_wait_scheduler_pkg.sv
// Shared definitions for the decode commit-wait scheduler:
// FSM state encodings and the default in-flight window size.
package decode_commit_wait_scheduler_pkg;

  typedef enum logic [1:0] {
    DECSCHED_RUN     = 2'd0,
    DECSCHED_DRAIN   = 2'd1,
    DECSCHED_WAIT_CW = 2'd2
  } decsched_state_t;

  localparam int DECSCHED_MAX_INFLIGHT = 16;

endpackage

// File: rtl/decode_commit_wait_scheduler_inflight_counter.sv
// In-flight instruction counter for the decode scheduler.
// Counts issued-but-uncommitted instructions. An issue and a commit in the
// same cycle cancel out. A commit with nothing in flight is dropped and
// latches a sticky underflow flag. Full also accounts for the instruction
// currently sitting in the output register, which is certain to issue.
module decode_sched_inflight_counter #(
  parameter int MAX_INFLIGHT = 16,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             iCLOCK,
  input  logic             iRESET,
  input  logic             iFLUSH,
  input  logic             iISSUE,
  input  logic             iCOMMIT,
  input  logic             iPENDING,
  output logic [CNT_W-1:0] oCOUNT,
  output logic             oFULL,
  output logic             oUNDERFLOW
);

  localparam logic [CNT_W:0]   MAX_C = (CNT_W + 1)'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [CNT_W:0]   occupied;

  // Next count: simultaneous issue and commit leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (iISSUE && !iCOMMIT) begin
      cnt_d = cnt_q + ONE_C;
    end else if (!iISSUE && iCOMMIT) begin
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q - ONE_C;
      end
    end
  end

  // Count and sticky error registers; flush discards all accounting.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (iFLUSH) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign occupied   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, iPENDING};
  assign oFULL      = (occupied >= MAX_C);
  assign oCOUNT     = cnt_q;
  assign oUNDERFLOW = err_q;

endmodule

// File: rtl/decode_commit_wait_scheduler.sv
// Issue scheduler between decode and dispatch.
// Registers decoded instructions with one cycle of latency, bounds the
// issued-but-uncommitted window and serialises commit-wait instructions
// (drain window, issue alone, hold until it commits).
// Optional feature macro: DECODE_SCHED_STALL_CNT_EN adds oSTALL_CYCLES,
// a saturating count of scheduler-caused upstream stall cycles.
module decode_commit_wait_scheduler
  import decode_commit_wait_scheduler_pkg::*;
#(
  parameter int  DATA_W       = 64,
  parameter int  MAX_INFLIGHT = DECSCHED_MAX_INFLIGHT,
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iFREE_DEFAULT,
  input  logic              iPREVIOUS_VALID,
  input  logic              iPREVIOUS_COMMIT_WAIT,
  input  logic [31:0]       iPREVIOUS_PC,
  input  logic [DATA_W-1:0] iPREVIOUS_DATA,
  output logic              oPREVIOUS_LOCK,
  output logic              oNEXT_VALID,
  output logic              oNEXT_COMMIT_WAIT,
  output logic [31:0]       oNEXT_PC,
  output logic [DATA_W-1:0] oNEXT_DATA,
  input  logic              iNEXT_LOCK,
  input  logic              iCOMMIT_VALID,
  output logic [CNT_W-1:0]  oINFLIGHT,
  output logic              oCOUNT_ERROR
`ifdef DECODE_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]       oSTALL_CYCLES
`endif
);

  decsched_state_t   state_q, state_d;
  logic              vld_q;
  logic              cw_q;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] data_q;
  logic              lock;
  logic              accept;
  logic              issue;
  logic              full;
  logic              drained;
  logic [CNT_W-1:0]  inflight;

  assign drained = !vld_q && (inflight == '0);
  assign accept  = iPREVIOUS_VALID && !lock;
  assign issue   = vld_q && !iNEXT_LOCK;

  // Upstream lock and next state; a CW only gets through from an empty pipe.
  always_comb begin
    state_d = state_q;
    lock    = 1'b1;
    case (state_q)
      DECSCHED_RUN: begin
        lock = iNEXT_LOCK || full || (iPREVIOUS_VALID && iPREVIOUS_COMMIT_WAIT);
        if (iPREVIOUS_VALID && iPREVIOUS_COMMIT_WAIT) state_d = DECSCHED_DRAIN;
      end
      DECSCHED_DRAIN: begin
        lock = !(drained && !iNEXT_LOCK);
        if (iPREVIOUS_VALID && drained && !iNEXT_LOCK) state_d = DECSCHED_WAIT_CW;
      end
      DECSCHED_WAIT_CW: begin
        lock = 1'b1;
        if (drained) state_d = DECSCHED_RUN;
      end
      default: begin
        lock    = 1'b1;
        state_d = DECSCHED_RUN;
      end
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= DECSCHED_RUN;
    end else if (iFREE_DEFAULT) begin
      state_q <= DECSCHED_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register: loads whenever downstream is free, a bubble if not accepted.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      vld_q  <= 1'b0;
      cw_q   <= 1'b0;
      pc_q   <= '0;
      data_q <= '0;
    end else if (iFREE_DEFAULT) begin
      vld_q  <= 1'b0;
      cw_q   <= 1'b0;
      pc_q   <= '0;
      data_q <= '0;
    end else if (!iNEXT_LOCK) begin
      vld_q  <= accept;
      cw_q   <= iPREVIOUS_COMMIT_WAIT;
      pc_q   <= iPREVIOUS_PC;
      data_q <= iPREVIOUS_DATA;
    end
  end

  decode_sched_inflight_counter #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_inflight (
    .iCLOCK     (iCLOCK),
    .iRESET     (iRESET),
    .iFLUSH     (iFREE_DEFAULT),
    .iISSUE     (issue),
    .iCOMMIT    (iCOMMIT_VALID),
    .iPENDING   (vld_q),
    .oCOUNT     (inflight),
    .oFULL      (full),
    .oUNDERFLOW (oCOUNT_ERROR)
  );

`ifdef DECODE_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles the scheduler itself held a valid instruction.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      stall_q <= '0;
    end else if (iFREE_DEFAULT) begin
      stall_q <= '0;
    end else if (iPREVIOUS_VALID && lock && !iNEXT_LOCK && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign oSTALL_CYCLES = stall_q;
`endif

  assign oPREVIOUS_LOCK    = lock;
  assign oNEXT_VALID       = vld_q;
  assign oNEXT_COMMIT_WAIT = cw_q;
  assign oNEXT_PC          = pc_q;
  assign oNEXT_DATA        = data_q;
  assign oINFLIGHT         = inflight;

endmodule

// File: tb/tb_decode_commit_wait_scheduler.sv
// Self-checking bench for decode_commit_wait_scheduler (MAX_INFLIGHT=4).
// Directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a behavioural model of the scheduler.
module tb_decode_commit_wait_scheduler;

  localparam int DW   = 64;
  localparam int MAXI = 4;
  localparam int CW_N = $clog2(MAXI + 1);

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_WAIT  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush, pv, pcw, nl, commit;
  logic [31:0]     pc;
  logic [DW-1:0]   data;
  logic            lock_o, vld_o, cw_o, err_o;
  logic [31:0]     pc_o;
  logic [DW-1:0]   data_o;
  logic [CW_N-1:0] infl_o;
`ifdef DECODE_SCHED_STALL_CNT_EN
  logic [31:0]     stall_o;
`endif

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int          m_mode;
  int          m_cnt;
  bit          m_v, m_cw, m_err, m_acc;
  logic [31:0] m_pc;
  logic [DW-1:0] m_data;
  longint      m_stall;

  always #5 clk = ~clk;

  decode_commit_wait_scheduler #(.DATA_W(DW), .MAX_INFLIGHT(MAXI)) dut (
    .iCLOCK               (clk),
    .iRESET               (rst),
    .iFREE_DEFAULT        (flush),
    .iPREVIOUS_VALID      (pv),
    .iPREVIOUS_COMMIT_WAIT(pcw),
    .iPREVIOUS_PC         (pc),
    .iPREVIOUS_DATA       (data),
    .oPREVIOUS_LOCK       (lock_o),
    .oNEXT_VALID          (vld_o),
    .oNEXT_COMMIT_WAIT    (cw_o),
    .oNEXT_PC             (pc_o),
    .oNEXT_DATA           (data_o),
    .iNEXT_LOCK           (nl),
    .iCOMMIT_VALID        (commit),
    .oINFLIGHT            (infl_o),
    .oCOUNT_ERROR         (err_o)
`ifdef DECODE_SCHED_STALL_CNT_EN
    ,
    .oSTALL_CYCLES        (stall_o)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_clear();
    m_mode = M_RUN; m_cnt = 0; m_v = 0; m_cw = 0; m_err = 0; m_acc = 0;
    m_pc = '0; m_data = '0; m_stall = 0;
  endfunction

  function automatic bit m_lock();
    if (m_mode == M_RUN)   return nl || ((m_cnt + int'(m_v)) >= MAXI) || (pv && pcw);
    if (m_mode == M_DRAIN) return !(!m_v && m_cnt == 0 && !nl);
    return 1'b1;
  endfunction

  function automatic void model_step();
    bit lk, iss, acc;
    lk  = m_lock();
    iss = m_v && !nl;
    acc = pv && !lk;
    m_acc = 0;
    if (flush) begin
      model_clear();
      return;
    end
    if (pv && lk && !nl && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (m_mode == M_RUN) begin
      if (pv && pcw) m_mode = M_DRAIN;
    end else if (m_mode == M_DRAIN) begin
      if (acc) m_mode = M_WAIT;
    end else begin
      if (!m_v && m_cnt == 0) m_mode = M_RUN;
    end
    if (iss && !commit) m_cnt++;
    else if (!iss && commit) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt--;
    end
    if (!nl) begin
      m_v = acc; m_cw = pcw; m_pc = pc; m_data = data;
    end
    m_acc = acc;
  endfunction

  // Model advances on the same edges as the DUT
  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else model_step();
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model_lock",  lock_o, m_lock());
      chk("model_valid", vld_o,  m_v);
      chk("model_cw",    cw_o,   m_cw);
      chk("model_pc",    pc_o,   m_pc);
      chk("model_data",  data_o, m_data);
      chk("model_infl",  infl_o, m_cnt);
      chk("model_err",   err_o,  m_err);
`ifdef DECODE_SCHED_STALL_CNT_EN
      chk("model_stall", stall_o, m_stall[31:0]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #2;
  endtask

  initial begin
    rst = 1; flush = 0; pv = 0; pcw = 0; nl = 0; commit = 0; pc = '0; data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    sample();
    chk("reset_valid", vld_o, 0);
    chk("reset_infl", infl_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_lock", lock_o, 0);

    // Window fill: 4 issue, 5th held until one commits
    pv = 1; pcw = 0; pc = 32'h100; data = 64'h1111;
    tick(); sample();
    chk("first_valid", vld_o, 1);
    chk("first_pc", pc_o, 32'h100);
    pc = 32'h104; tick();
    pc = 32'h108; tick();
    pc = 32'h10C; tick();
    pc = 32'h110; sample();
    chk("full_lock", lock_o, 1);
    chk("full_infl3", infl_o, 3);
    tick(); sample();
    chk("full_infl4", infl_o, 4);
    chk("full_bubble", vld_o, 0);
    commit = 1; tick(); commit = 0; sample();
    chk("after_commit_infl", infl_o, 3);
    chk("after_commit_lock", lock_o, 0);
    tick(); pv = 0; sample();
    chk("fifth_valid", vld_o, 1);
    chk("fifth_pc", pc_o, 32'h110);

    // Drain with commits, then one commit too many
    commit = 1; repeat (5) tick(); commit = 0; sample();
    chk("underflow_infl", infl_o, 0);
    chk("underflow_err", err_o, 1);
    repeat (2) tick(); sample();
    chk("err_sticky", err_o, 1);

    // Asynchronous reset mid-cycle
    @(posedge clk); #3 rst = 1; #1;
    chk("areset_valid", vld_o, 0);
    chk("areset_err", err_o, 0);
    chk("areset_infl", infl_o, 0);
    repeat (2) tick();
    rst = 0;

    // Commit-wait with two in flight
    pv = 1; pcw = 0; pc = 32'h200; data = 64'hA; tick();
    pc = 32'h204; tick();
    pcw = 1; pc = 32'h300; sample();
    chk("cw_lock_run", lock_o, 1);
    tick(); sample();
    chk("cw_drain_infl", infl_o, 2);
    chk("cw_drain_bubble", vld_o, 0);
    chk("cw_drain_lock", lock_o, 1);
    commit = 1; tick(); tick(); commit = 0; sample();
    chk("cw_drained_unlock", lock_o, 0);
    tick(); pcw = 0; pc = 32'h400; sample();
    chk("cw_out_valid", vld_o, 1);
    chk("cw_out_tag", cw_o, 1);
    chk("cw_out_pc", pc_o, 32'h300);
    chk("cw_next_held", lock_o, 1);
    tick(); tick(); sample();
    chk("cw_issued_infl", infl_o, 1);
    chk("cw_wait_lock", lock_o, 1);
    commit = 1; tick(); commit = 0; sample();
    chk("cw_commit_lock", lock_o, 1);
    tick(); sample();
    chk("cw_back_run", lock_o, 0);
    tick(); pv = 0; sample();
    chk("post_cw_pc", pc_o, 32'h400);

    // Downstream stall holds the output register
    nl = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); sample();
      chk("stall_valid", vld_o, 1);
      chk("stall_pc", pc_o, 32'h400);
      chk("stall_infl", infl_o, 0);
    end
    nl = 0; tick(); sample();
    chk("stall_release_infl", infl_o, 1);
    chk("stall_release_bubble", vld_o, 0);

    // Flush while draining for a commit-wait
    pv = 1; pcw = 1; pc = 32'h600; tick();
    flush = 1; tick(); flush = 0; sample();
    chk("flush_infl", infl_o, 0);
    chk("flush_valid", vld_o, 0);
    chk("flush_err", err_o, 0);
    pv = 0; tick();

    // Randomized traffic, held by the source until accepted
    for (int i = 0; i < 3000; i++) begin
      if (m_acc || !pv) begin
        pv   = ($urandom % 4) != 0;
        pcw  = ($urandom % 8) == 0;
        pc   = $urandom;
        data = {$urandom, $urandom};
      end
      nl     = ($urandom % 4) == 0;
      commit = (m_cnt > 0) ? (($urandom % 3) != 0) : (($urandom % 64) == 0);
      flush  = ($urandom % 150) == 0;
      tick();
    end
    pv = 0; nl = 0; commit = 0; flush = 0;
    tick(); sample();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
